// File: rtl/pipe_stage_register.sv
// Pipeline-stage register with valid/ready handshake and a one-entry skid buffer.
// Define PIPE_STAGE_DATA_RESET_EN to also clear the data registers on rst.
module pipe_stage_register #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;

  logic accept;
  logic take;
  logic load_main;
  logic main_from_skid;
  logic load_skid;

  // in_ready is a function of state and flush only, never of out_ready.
  assign out_valid = (state_q != StEmpty);
  assign in_ready  = (state_q != StFull) & ~flush;
  assign occupancy = state_q;
  assign out_data  = main_q;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_comb begin
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      unique case (state_q)
        StEmpty: load_main = accept;
        StBusy: begin
          load_main = accept & take;
          load_skid = accept & ~take;
        end
        StFull: begin
          load_main      = take;
          main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (accept) state_q <= StBusy;
        StBusy: begin
          if (accept && !take)      state_q <= StFull;
          else if (take && !accept) state_q <= StEmpty;
        end
        StFull:  if (take) state_q <= StBusy;
        default: state_q <= StEmpty;  // illegal encoding recovers to empty
      endcase
    end
  end

`ifdef PIPE_STAGE_DATA_RESET_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (load_main) main_q <= main_from_skid ? skid_q : in_data;
    if (load_skid) skid_q <= in_data;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_register.sv
// Bench for pipe_stage_register: directed vector table plus randomized queue-model check.
module tb_pipe_stage_register;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy;

  int tests = 0;
  int fails = 0;

  pipe_stage_register #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         r;
    logic         f;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         ev;
    logic         er;
    logic [1:0]   eo;
    logic [W-1:0] ed;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic iv, input logic [W-1:0] d,
                     input logic ordy, input logic ev, input logic er, input logic [1:0] eo,
                     input logic [W-1:0] ed);
    vec_t v;
    v = '{r: r, f: f, iv: iv, d: d, ordy: ordy, ev: ev, er: er, eo: eo, ed: ed};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [W-1:0] d,
                       input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  logic [W-1:0] q[$];
  logic         r_b, f_b, iv_b, ordy_b, acc, tk;
  logic [W-1:0] d_b;
  int unsigned  pct;

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_occupancy", W'(occupancy), W'(0));
`ifdef PIPE_STAGE_DATA_RESET_EN
    chk("reset_out_data", out_data, '0);
`endif

    // streaming
    add(0, 0, 1, 32'h11, 1, 1, 1, 1, 32'h11);
    add(0, 0, 1, 32'h22, 1, 1, 1, 1, 32'h22);
    add(0, 0, 1, 32'h33, 1, 1, 1, 1, 32'h33);
    add(0, 0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
    // backpressure then full hold with 0xFF offered
    add(0, 0, 1, 32'hA1, 0, 1, 1, 1, 32'hA1);
    add(0, 0, 1, 32'hA2, 0, 1, 0, 2, 32'hA1);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 32'hFF, 0, 1, 0, 2, 32'hA1);
    add(0, 0, 0, 32'h0,  1, 1, 1, 1, 32'hA2);
    add(0, 0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
    // flush while full, 0x55 offered in the flush cycle
    add(0, 0, 1, 32'hB1, 0, 1, 1, 1, 32'hB1);
    add(0, 0, 1, 32'hB2, 0, 1, 0, 2, 32'hB1);
    add(0, 1, 1, 32'h55, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
    // rst while full with out_ready high
    add(0, 0, 1, 32'hC1, 0, 1, 1, 1, 32'hC1);
    add(0, 0, 1, 32'hC2, 0, 1, 0, 2, 32'hC1);
    add(1, 0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,  1, 0, 1, 0, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), W'(out_valid), W'(vecs[i].ev));
      chk($sformatf("vec%0d_in_ready", i), W'(in_ready), W'(vecs[i].er));
      chk($sformatf("vec%0d_occupancy", i), W'(occupancy), W'(vecs[i].eo));
      if (vecs[i].ev) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].ed);
    end

    // random phase: reference is an ordered queue of at most two items
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    q.delete();
    pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) pct = $urandom_range(10, 95);
      r_b    = ($urandom_range(0, 63) == 0);
      f_b    = ($urandom_range(0, 15) == 0);
      iv_b   = $urandom_range(0, 1) == 1;
      ordy_b = ($urandom_range(0, 99) < pct);
      d_b    = $urandom;
      drive(r_b, f_b, iv_b, d_b, ordy_b);
      #1;
      chk("rnd_in_ready_pre", W'(in_ready), W'(q.size() < 2 && !f_b));
      acc = iv_b && (q.size() < 2) && !f_b;
      tk  = (q.size() > 0) && ordy_b;
      @(posedge clk);
      if (r_b || f_b) begin
        q.delete();
      end else begin
        if (tk)  void'(q.pop_front());
        if (acc) q.push_back(d_b);
      end
      #1;
      chk("rnd_out_valid", W'(out_valid), W'(q.size() > 0));
      chk("rnd_occupancy", W'(occupancy), W'(q.size()));
      if (q.size() > 0) chk("rnd_out_data", out_data, q[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
